// File: rtl/branch_flag_unit_if.sv
// Execute-stage bus between the pipeline and branch_flag_unit.
// master: pipeline side (drives the EX instruction, receives redirect/flags).
// slave : branch_flag_unit side.
interface branch_flag_unit_if #(
   parameter int PC_W  = 16,
   parameter int IMM_W = 12
);
   logic             ex_valid;
   logic             stall;
   logic [3:0]       ex_opcode;
   logic [PC_W-1:0]  ex_pc;
   logic [IMM_W-1:0] ex_imm;
   logic             alu_n;
   logic             alu_z;
   logic             flagN;
   logic             flagZ;
   logic             pc_load;
   logic [PC_W-1:0]  pc_target;
   logic             flush;
   logic             halted;

   modport master (
      output ex_valid, stall, ex_opcode, ex_pc, ex_imm, alu_n, alu_z,
      input  flagN, flagZ, pc_load, pc_target, flush, halted
   );

   modport slave (
      input  ex_valid, stall, ex_opcode, ex_pc, ex_imm, alu_n, alu_z,
      output flagN, flagZ, pc_load, pc_target, flush, halted
   );
endinterface

// File: rtl/branch_flag_unit.sv
// Execute-stage branch resolution and N/Z condition-flag register.
// Captures cmp flags, resolves beq/bgt/blt/b against the registered flags,
// issues a one-cycle PC redirect, flushes the wrong path and latches halt.
// Optional feature macro: BRANCH_STATS_EN adds a saturating 16-bit
// taken-branch counter on port taken_count.
// rst is asynchronous and active-low.
module branch_flag_unit #(
   parameter int PC_W         = 16,
   parameter int IMM_W        = 12,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   branch_flag_unit_if.slave    bus
`ifdef BRANCH_STATS_EN
   ,
   output logic [15:0]          taken_count
`endif
);

   localparam logic [3:0] OP_BEQ  = 4'b0100;
   localparam logic [3:0] OP_BGT  = 4'b0101;
   localparam logic [3:0] OP_BLT  = 4'b0110;
   localparam logic [3:0] OP_B    = 4'b0111;
   localparam logic [3:0] OP_CMP  = 4'b1011;
   localparam logic [3:0] OP_HALT = 4'b1111;

   typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_HALT} state_t;

   state_t          state_reg, state_next;
   logic [2:0]      cnt_reg, cnt_next;
   logic            flag_n_reg, flag_n_next;
   logic            flag_z_reg, flag_z_next;
   logic            pc_load_reg, pc_load_next;
   logic [PC_W-1:0] pc_target_reg, pc_target_next;

   logic [IMM_W-1:0] imm_raw;
   logic [PC_W-1:0]  imm_sext;
   logic             eval;
   logic             is_branch;
   logic             cond_met;
   logic             taken;

   assign imm_raw   = bus.ex_imm;
   assign imm_sext  = PC_W'($signed(imm_raw));
   assign eval      = (state_reg == ST_RUN) && bus.ex_valid && !bus.stall;
   assign is_branch = (bus.ex_opcode[3:2] == 2'b01);
   assign taken     = eval && is_branch && cond_met;

   // Branch condition from the registered flags (cmp result of the previous cycle).
   always_comb begin
      cond_met = 1'b0;
      case (bus.ex_opcode)
         OP_BEQ:  cond_met = flag_z_reg;
         OP_BGT:  cond_met = !flag_n_reg && !flag_z_reg;
         OP_BLT:  cond_met = flag_n_reg;
         OP_B:    cond_met = 1'b1;
         default: cond_met = 1'b0;
      endcase
   end

   // Next-state logic; everything holds by default, redirect strobe defaults low.
   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      flag_n_next    = flag_n_reg;
      flag_z_next    = flag_z_reg;
      pc_load_next   = 1'b0;
      pc_target_next = pc_target_reg;
      case (state_reg)
         ST_RUN: begin
            if (eval) begin
               if (bus.ex_opcode == OP_CMP) begin
                  flag_n_next = bus.alu_n;
                  flag_z_next = bus.alu_z;
               end
               if (bus.ex_opcode == OP_HALT) begin
                  state_next = ST_HALT;
               end
               if (taken) begin
                  pc_load_next   = 1'b1;
                  pc_target_next = bus.ex_pc + imm_sext;
                  state_next     = ST_FLUSH;
                  cnt_next       = 3'(FLUSH_CYCLES);
               end
            end
         end
         ST_FLUSH: begin
            // Wrong-path instructions are ignored; only unstalled cycles count.
            if (!bus.stall) begin
               if (cnt_reg <= 3'd1) begin
                  state_next = ST_RUN;
                  cnt_next   = 3'd0;
               end else begin
                  cnt_next = cnt_reg - 3'd1;
               end
            end
         end
         ST_HALT: begin
            state_next = ST_HALT;
         end
         default: begin
            state_next = ST_RUN;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= ST_RUN;
         cnt_reg       <= 3'd0;
         flag_n_reg    <= 1'b0;
         flag_z_reg    <= 1'b0;
         pc_load_reg   <= 1'b0;
         pc_target_reg <= '0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         flag_n_reg    <= flag_n_next;
         flag_z_reg    <= flag_z_next;
         pc_load_reg   <= pc_load_next;
         pc_target_reg <= pc_target_next;
      end
   end

   // A stall masks the redirect strobe; the register has already cleared, so it is never replayed.
   assign bus.flagN     = flag_n_reg;
   assign bus.flagZ     = flag_z_reg;
   assign bus.pc_load   = pc_load_reg && !bus.stall;
   assign bus.pc_target = pc_target_reg;
   assign bus.flush     = (state_reg == ST_FLUSH);
   assign bus.halted    = (state_reg == ST_HALT);

`ifdef BRANCH_STATS_EN
   logic [15:0] taken_count_reg;

   // Saturating count of taken branches.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         taken_count_reg <= 16'd0;
      end else if (taken && (taken_count_reg != 16'hFFFF)) begin
         taken_count_reg <= taken_count_reg + 16'd1;
      end
   end

   assign taken_count = taken_count_reg;
`endif

endmodule

// File: tb/tb_branch_flag_unit.sv
// Directed testbench for branch_flag_unit (FLUSH_CYCLES = 2).
module tb_branch_flag_unit;

   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_BEQ  = 4'b0100;
   localparam logic [3:0] OP_BGT  = 4'b0101;
   localparam logic [3:0] OP_BLT  = 4'b0110;
   localparam logic [3:0] OP_B    = 4'b0111;
   localparam logic [3:0] OP_CMP  = 4'b1011;
   localparam logic [3:0] OP_HALT = 4'b1111;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   tests_run = 0;
   int   tests_failed = 0;

   branch_flag_unit_if #(.PC_W(16), .IMM_W(12)) bus ();

`ifdef BRANCH_STATS_EN
   logic [15:0] taken_count;
`endif

   branch_flag_unit #(.PC_W(16), .IMM_W(12), .FLUSH_CYCLES(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus)
`ifdef BRANCH_STATS_EN
      ,
      .taken_count (taken_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end else begin
         $display("[TB] ok   %s = 0x%0h", tag, obs);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [3:0] op, input logic [15:0] pc, input logic [11:0] imm,
                          input logic n, input logic z);
      bus.ex_valid  = 1'b1;
      bus.ex_opcode = op;
      bus.ex_pc     = pc;
      bus.ex_imm    = imm;
      bus.alu_n     = n;
      bus.alu_z     = z;
   endtask

   task automatic idle();
      bus.ex_valid  = 1'b0;
      bus.ex_opcode = OP_NOP;
   endtask

   initial begin
      bus.stall = 1'b0;
      bus.ex_pc = 16'h0;
      bus.ex_imm = 12'h0;
      bus.alu_n = 1'b0;
      bus.alu_z = 1'b0;
      idle();

      // Reset state
      step();
      step();
      check("rst_flags",  {bus.flagN, bus.flagZ}, 2'b00);
      check("rst_pcload", bus.pc_load, 0);
      check("rst_target", bus.pc_target, 16'h0000);
      check("rst_flush",  bus.flush, 0);
      check("rst_halted", bus.halted, 0);
      rst = 1'b1;
      step();

      // cmp N=1 Z=0 then blt 0x0010 + (-4) -> 0x000C
      present(OP_CMP, 16'h0000, 12'h000, 1'b1, 1'b0);
      step();
      check("cmp1_flags", {bus.flagN, bus.flagZ}, 2'b10);
      check("cmp1_pcload", bus.pc_load, 0);
      present(OP_BLT, 16'h0010, 12'hFFC, 1'b0, 1'b0);
      step();
      check("blt_pcload", bus.pc_load, 1);
      check("blt_target", bus.pc_target, 16'h000C);
      check("blt_flush1", bus.flush, 1);
      idle();
      step();
      check("blt_pcload_off", bus.pc_load, 0);
      check("blt_flush2", bus.flush, 1);
      check("blt_target_hold", bus.pc_target, 16'h000C);
      step();
      check("blt_flush_end", bus.flush, 0);

      // cmp Z=1, bgt not taken, beq taken
      present(OP_CMP, 16'h0000, 12'h000, 1'b0, 1'b1);
      step();
      check("cmp2_flags", {bus.flagN, bus.flagZ}, 2'b01);
      present(OP_BGT, 16'h0100, 12'h020, 1'b0, 1'b0);
      step();
      check("bgt_pcload", bus.pc_load, 0);
      check("bgt_flush", bus.flush, 0);
      check("bgt_target_hold", bus.pc_target, 16'h000C);
      present(OP_BEQ, 16'h0100, 12'h020, 1'b0, 1'b0);
      step();
      check("beq_pcload", bus.pc_load, 1);
      check("beq_target", bus.pc_target, 16'h0120);
      present(OP_CMP, 16'h0000, 12'h000, 1'b1, 1'b0);
      step();
      check("flushcmp_flags", {bus.flagN, bus.flagZ}, 2'b01);
      check("flushcmp_flush", bus.flush, 1);
      step();
      check("flushcmp_end", bus.flush, 0);
      check("flushcmp_flags2", {bus.flagN, bus.flagZ}, 2'b01);

      // b with wrap: 0xFFFE + 4 -> 0x0002, then stall in the flush window
      present(OP_B, 16'hFFFE, 12'h004, 1'b0, 1'b0);
      step();
      check("bwrap_pcload", bus.pc_load, 1);
      check("bwrap_target", bus.pc_target, 16'h0002);
      idle();
      step();
      check("bwrap_flush1", bus.flush, 1);
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("stall%0d_flush", i), bus.flush, 1);
         check($sformatf("stall%0d_pcload", i), bus.pc_load, 0);
      end
      bus.stall = 1'b0;
      step();
      check("stall_release_flush", bus.flush, 0);

      // Stalled taken branch is deferred until the stall drops
      present(OP_B, 16'h0200, 12'h7FF, 1'b0, 1'b0);
      bus.stall = 1'b1;
      step();
      check("stallbr_pcload", bus.pc_load, 0);
      check("stallbr_flush", bus.flush, 0);
      check("stallbr_target", bus.pc_target, 16'h0002);
      bus.stall = 1'b0;
      step();
      check("stallbr_pcload2", bus.pc_load, 1);
      check("stallbr_target2", bus.pc_target, 16'h09FF);
      idle();
      step();
      step();
      check("stallbr_flush_end", bus.flush, 0);

      // halt, then ignored b/cmp, then async reset
      present(OP_HALT, 16'h0000, 12'h000, 1'b0, 1'b0);
      step();
      check("halt_halted", bus.halted, 1);
      present(OP_B, 16'h0300, 12'h010, 1'b0, 1'b0);
      step();
      check("halt_b_pcload", bus.pc_load, 0);
      check("halt_b_flush", bus.flush, 0);
      present(OP_CMP, 16'h0000, 12'h000, 1'b1, 1'b0);
      step();
      check("halt_cmp_flags", {bus.flagN, bus.flagZ}, 2'b01);
      check("halt_still", bus.halted, 1);
      idle();
      #2;
      rst = 1'b0;
      #1;
      check("async_halted", bus.halted, 0);
      check("async_flags", {bus.flagN, bus.flagZ}, 2'b00);
      check("async_target", bus.pc_target, 16'h0000);
      step();
      rst = 1'b1;
      step();

      // Reset in the middle of a flush
      present(OP_B, 16'h0040, 12'h010, 1'b0, 1'b0);
      step();
      check("midflush_pcload", bus.pc_load, 1);
      check("midflush_target", bus.pc_target, 16'h0050);
      idle();
      #2;
      rst = 1'b0;
      #1;
      check("midflush_rst_flush", bus.flush, 0);
      check("midflush_rst_pcload", bus.pc_load, 0);
      step();
      rst = 1'b1;
      step();
      check("midflush_after", bus.flush, 0);

      // 5 taken b, 3 not-taken beq (flags are 0 after reset)
      for (int i = 0; i < 8; i++) begin
         present((i < 5) ? OP_B : OP_BEQ, 16'h1000, 12'h001, 1'b0, 1'b0);
         step();
         check($sformatf("stats%0d_pcload", i), bus.pc_load, (i < 5) ? 1 : 0);
         idle();
         if (i < 5) begin
            step();
            step();
         end
      end
`ifdef BRANCH_STATS_EN
      check("taken_count", taken_count, 16'd5);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/branch_flag_unit.md
# branch_flag_unit

Execute-stage branch resolution and condition-flag register for the pipelined CPU. It captures the N/Z result of `cmp`, evaluates `beq`/`bgt`/`blt`/`b` in EX, and redirects the PC. It flushes the wrong-path instructions behind a taken branch and latches `halt`. Its registered `flagN`/`flagZ` feed the control unit's flag inputs directly.

## Interface
- `PC_W`, 16, PC / instruction-address width (word addresses)
- `IMM_W`, 12, branch offset width (two's complement)
- `FLUSH_CYCLES`, 2, cycles `flush` stays high after a taken branch (1..7)
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `ex_valid`  in  1  instruction in EX is valid
- `stall`  in  1  pipeline stall; freezes this block
- `ex_opcode`  in  4  opcode of EX instruction
- `ex_pc`  in  PC_W  address of EX instruction
- `ex_imm`  in  IMM_W  branch offset of EX instruction
- `alu_n`, `alu_z`  in  1 each  ALU negative/zero result of EX instruction
- `flagN`, `flagZ`  out  1 each  registered condition flags
- `pc_load`  out  1  one-cycle PC redirect strobe
- `pc_target`  out  PC_W  redirect address, valid with `pc_load`
- `flush`  out  1  kill IF/ID and ID/EX contents
- `halted`  out  1  processor halted
- `taken_count`  out  16  taken-branch counter (only with `BRANCH_STATS_EN`)

## Operation
- Opcodes handled: 0100 `beq`, 0101 `bgt`, 0110 `blt`, 0111 `b`, 1011 `cmp`, 1111 `halt`. All others are ignored.
- An instruction is evaluated when the block is in RUN, `ex_valid`=1 and `stall`=0.
- `cmp` evaluated: `flagN`<=`alu_n`, `flagZ`<=`alu_z`. No other opcode writes the flags.
- Branch conditions use registered flags: `beq` Z=1; `bgt` N=0 & Z=0; `blt` N=1; `b` always.
- Taken branch: `pc_target`<=`ex_pc` + sign-extend(`ex_imm`), truncated to PC_W (wraps mod 2^PC_W).
  - `pc_load`<=1 for exactly one cycle.
  - Enters FLUSH with counter = FLUSH_CYCLES.
- Not-taken branch: no output change.
- `halt` evaluated: enters HALT.
- States:
  - RUN: evaluate as above.
  - FLUSH: `flush`=1. Counter decrements each unstalled cycle. Exit to RUN the cycle after the counter reaches 1. EX instructions are ignored, including `cmp`, `halt` and branches, because they are wrong-path.
  - HALT: `halted`=1. Nothing is evaluated and flags are frozen. Only reset exits.
- `stall`=1: all state, flags, counter and `pc_target` hold. `pc_load` forced 0 and not re-issued after the stall. `flush` holds its current value.
- `pc_target` holds its last value when `pc_load`=0.

## Timing
- Reset (async assert, sync-safe deassert at clock edge): RUN, `flagN`=`flagZ`=0, `pc_load`=0, `pc_target`=0, `flush`=0, `halted`=0, counter 0, `taken_count`=0.
- Reset mid-FLUSH or in HALT returns to RUN immediately. No pending redirect survives.
- Flag latency: `cmp` in EX at cycle t gives flags visible at t+1. A branch in EX at t+1 uses the new flags, so no forwarding is needed.
- Taken branch in EX at cycle t:
  - `pc_load`=1, `pc_target` valid and `flush`=1 at t+1.
  - `flush` stays high through t+FLUSH_CYCLES (unstalled).
  - RUN at t+FLUSH_CYCLES+1.
- `halt` in EX at t gives `halted`=1 from t+1.
- Simultaneous `stall` and taken branch: the branch is not evaluated. It is re-evaluated when the stall drops, if still presented.

## Configuration
- `BRANCH_STATS_EN` defined: 16-bit `taken_count` increments on every taken branch, saturates at 0xFFFF, and clears on reset.
- `BRANCH_STATS_EN` not defined: port `taken_count` and its counter are absent; behaviour is otherwise identical.

## Test plan
- `cmp` with `alu_n`=1, `alu_z`=0, then `blt` at `ex_pc`=0x0010, `ex_imm`=0xFFC -> flags N=1 Z=0; next cycle `pc_load`=1, `pc_target`=0x000C; `flush` high 2 cycles.
- `cmp` Z=1, then `bgt` -> not taken; `pc_load` stays 0; then `beq` -> taken, `pc_target`=`ex_pc`+imm.
- Taken `b` at `ex_pc`=0xFFFE, `ex_imm`=0x004 -> `pc_target`=0x0002 (wrap). A `cmp` presented during FLUSH leaves the flags unchanged.
- Taken branch with `stall` raised during the flush window for 3 cycles -> `flush` held high, counter frozen; total unstalled flush cycles = 2.
- `halt` -> `halted`=1 next cycle; subsequent `b`/`cmp` are ignored. Assert `rst`=0 asynchronously mid-cycle -> all outputs 0 immediately.
- With `BRANCH_STATS_EN`: 5 taken and 3 not-taken branches -> `taken_count`=5.
